// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver running entirely in the scki domain.
// bck, lrck and adata are oversampled through synchroniser chains. The
// bck rising edges are detected, and MSB-first DATA_WIDTH-bit words are
// deserialised and paired into left/right samples. Each complete pair is
// presented on a valid/ready port.
// Ports:
//   scki        - system clock, all logic on the rising edge
//   rst         - asynchronous active-low reset
//   bck         - I2S bit clock (asynchronous, <= scki/4)
//   lrck        - I2S word select
//   adata       - I2S serial data, sampled on bck rising edge
//   i_ready     - downstream accepts the current pair
//   o_left      - left sample of the current pair
//   o_right     - right sample of the current pair
//   o_valid     - pair available, held until accepted
//   o_overrun   - one-cycle pulse: unaccepted pair overwritten
//   o_frame_err - one-cycle pulse: slot ended before DATA_WIDTH bits
module i2s_rx #(
    parameter int   DATA_WIDTH  = 24,
    parameter int   SYNC_STAGES = 2,
    parameter logic LEFT_LRCK   = 1'b0
) (
    input  logic                  scki,
    input  logic                  rst,
    input  logic                  bck,
    input  logic                  lrck,
    input  logic                  adata,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_left,
    output logic [DATA_WIDTH-1:0] o_right,
    output logic                  o_valid,
    output logic                  o_overrun,
    output logic                  o_frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PAD   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] bck_sync_r, lrck_sync_r, adata_sync_r;
    logic                   bck_q_s, lrck_q_s, adata_q_s;
    logic                   bck_prev_r, rise_r, lrck_smp_r, adata_smp_r;
    logic                   lrck_prev_r, ref_valid_r, slot_lrck_r;
    logic                   boundary_s;
    state_t                 state_r, state_nxt_s;
    logic                   shift_en_s, clr_cnt_s, done_s, short_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [DATA_WIDTH-1:0]  shift_r, word_r, left_hold_r;
    logic                   word_done_r, word_left_r, left_held_r;
    logic                   pair_load_s;

    assign bck_q_s   = bck_sync_r[SYNC_STAGES-1];
    assign lrck_q_s  = lrck_sync_r[SYNC_STAGES-1];
    assign adata_q_s = adata_sync_r[SYNC_STAGES-1];

    // Synchroniser chains for the three asynchronous I2S inputs
    always_ff @(posedge scki or negedge rst) begin
        if (!rst) begin
            bck_sync_r   <= '0;
            lrck_sync_r  <= '0;
            adata_sync_r <= '0;
        end else begin
            bck_sync_r   <= {bck_sync_r[SYNC_STAGES-2:0], bck};
            lrck_sync_r  <= {lrck_sync_r[SYNC_STAGES-2:0], lrck};
            adata_sync_r <= {adata_sync_r[SYNC_STAGES-2:0], adata};
        end
    end

    // bck rising-edge strobe, registered together with the lrck/adata sample it qualifies
    always_ff @(posedge scki or negedge rst) begin
        if (!rst) begin
            bck_prev_r  <= 1'b0;
            rise_r      <= 1'b0;
            lrck_smp_r  <= 1'b0;
            adata_smp_r <= 1'b0;
        end else begin
            bck_prev_r  <= bck_q_s;
            rise_r      <= bck_q_s & ~bck_prev_r;
            lrck_smp_r  <= lrck_q_s;
            adata_smp_r <= adata_q_s;
        end
    end

    // A boundary needs a reference lrck from an earlier bck edge.
    // Without one, the first edge after reset could look like a spurious slot start.
    assign boundary_s = rise_r & ref_valid_r & (lrck_smp_r != lrck_prev_r);

    // FSM state register
    always_ff @(posedge scki or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic, advancing only on bck edges
    always_comb begin
        state_nxt_s = state_r;
        if (rise_r) begin
            case (state_r)
                ST_IDLE:  if (boundary_s) state_nxt_s = ST_DELAY; else state_nxt_s = ST_IDLE;
                ST_DELAY: if (boundary_s) state_nxt_s = ST_DELAY; else state_nxt_s = ST_SHIFT;
                ST_SHIFT: begin
                    if (boundary_s)             state_nxt_s = ST_DELAY;
                    else if (cnt_r == CNT_LAST) state_nxt_s = ST_PAD;
                    else                        state_nxt_s = ST_SHIFT;
                end
                ST_PAD:   if (boundary_s) state_nxt_s = ST_DELAY; else state_nxt_s = ST_PAD;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM control strobes. DELAY has already swallowed the delay bit, so its edge carries the MSB.
    always_comb begin
        shift_en_s = 1'b0;
        clr_cnt_s  = 1'b0;
        done_s     = 1'b0;
        short_s    = 1'b0;
        if (rise_r) begin
            case (state_r)
                ST_IDLE:  clr_cnt_s = boundary_s;
                ST_DELAY, ST_SHIFT: begin
                    if (boundary_s) begin
                        short_s   = 1'b1;
                        clr_cnt_s = 1'b1;
                    end else begin
                        shift_en_s = 1'b1;
                        done_s     = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
                    end
                end
                ST_PAD:   clr_cnt_s = boundary_s;
                default:  clr_cnt_s = 1'b0;
            endcase
        end else begin
            shift_en_s = 1'b0;
        end
    end

    // Deserialiser datapath: lrck history, shift register, saturating bit counter
    always_ff @(posedge scki or negedge rst) begin
        if (!rst) begin
            lrck_prev_r <= 1'b0;
            ref_valid_r <= 1'b0;
            slot_lrck_r <= 1'b0;
            cnt_r       <= '0;
            shift_r     <= '0;
        end else begin
            if (rise_r) begin
                lrck_prev_r <= lrck_smp_r;
                ref_valid_r <= 1'b1;
            end
            if (boundary_s) slot_lrck_r <= lrck_smp_r;
            if (clr_cnt_s) cnt_r <= '0;
            else if (shift_en_s && (cnt_r != CNT_FULL)) cnt_r <= cnt_r + CNT_W'(1);
            if (shift_en_s) shift_r <= {shift_r[DATA_WIDTH-2:0], adata_smp_r};
        end
    end

    // Completed-word stage and the frame-error pulse
    always_ff @(posedge scki or negedge rst) begin
        if (!rst) begin
            word_done_r <= 1'b0;
            word_left_r <= 1'b0;
            word_r      <= '0;
            o_frame_err <= 1'b0;
        end else begin
            word_done_r <= done_s;
            o_frame_err <= short_s;
            if (done_s) begin
                word_r      <= {shift_r[DATA_WIDTH-2:0], adata_smp_r};
                word_left_r <= (slot_lrck_r == LEFT_LRCK);
            end
        end
    end

    // A right word only forms a pair when a left word is already held
    assign pair_load_s = word_done_r & ~word_left_r & left_held_r;

    // Pairing and output handshake; a freshly loaded pair outranks a transfer
    always_ff @(posedge scki or negedge rst) begin
        if (!rst) begin
            left_hold_r <= '0;
            left_held_r <= 1'b0;
            o_left      <= '0;
            o_right     <= '0;
            o_valid     <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (short_s) begin
                left_held_r <= 1'b0;
            end else if (word_done_r && word_left_r) begin
                left_hold_r <= word_r;
                left_held_r <= 1'b1;
            end else if (pair_load_s) begin
                left_held_r <= 1'b0;
            end
            if (pair_load_s) begin
                o_left    <= left_hold_r;
                o_right   <= word_r;
                o_valid   <= 1'b1;
                o_overrun <= o_valid & ~i_ready;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed self-checking bench for i2s_rx.
// Stimulus drives I2S frames with 32-bit slots and bck = scki/4. Expected
// pairs are queued as frames are driven. A negedge monitor pops a pair and
// compares it on every handshake transfer.
module tb_i2s_rx;
    logic        scki = 1'b0;
    logic        rst = 1'b0;
    logic        bck = 1'b0;
    logic        lrck = 1'b1;
    logic        adata = 1'b0;
    logic        i_ready = 1'b1;
    logic [23:0] o_left, o_right;
    logic        o_valid, o_overrun, o_frame_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;
    int unexp_cnt = 0;
    logic [47:0] exp_q[$];
    logic [23:0] lut[8];

    i2s_rx #(.DATA_WIDTH(24), .SYNC_STAGES(2), .LEFT_LRCK(1'b0)) dut (
        .scki(scki), .rst(rst), .bck(bck), .lrck(lrck), .adata(adata),
        .i_ready(i_ready), .o_left(o_left), .o_right(o_right),
        .o_valid(o_valid), .o_overrun(o_overrun), .o_frame_err(o_frame_err)
    );

    always #5 scki = ~scki;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Monitor: pulse counters and scoreboard comparison on each transfer
    always @(negedge scki) begin
        if (rst) begin
            if (o_overrun) ovr_cnt++;
            if (o_frame_err) ferr_cnt++;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    unexp_cnt++;
                end else begin
                    logic [47:0] e;
                    e = exp_q.pop_front();
                    check("pair_left", {24'h0, o_left}, {24'h0, e[47:24]});
                    check("pair_right", {24'h0, o_right}, {24'h0, e[23:0]});
                end
            end
        end
    end

    task automatic send_bit(input logic lv, input logic d);
        lrck = lv;
        adata = d;
        #20 bck = 1'b1;
        #20 bck = 1'b0;
    endtask

    // Bit 0 of a slot is the I2S delay bit; the word follows MSB first, then zero padding
    task automatic send_slot(input logic lv, input logic [23:0] w, input int len);
        for (int i = 0; i < len; i++) begin
            if (i >= 1 && i <= 24) send_bit(lv, w[24-i]);
            else send_bit(lv, 1'b0);
        end
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r, input bit push);
        if (push) exp_q.push_back({l, r});
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge scki);
        check(tag, 48'(exp_q.size()), 48'd0);
    endtask

    task automatic sync_pt();
        @(posedge scki);
        #2;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        lut[0] = 24'h000000; lut[1] = 24'h5A8279; lut[2] = 24'h7FFFFF; lut[3] = 24'h5A8279;
        lut[4] = 24'h000000; lut[5] = 24'hA57D87; lut[6] = 24'h800001; lut[7] = 24'hA57D87;

        // Reset state
        repeat (3) sync_pt();
        check("rst_left", {24'h0, o_left}, 48'd0);
        check("rst_right", {24'h0, o_right}, 48'd0);
        check("rst_valid", {47'h0, o_valid}, 48'd0);
        check("rst_overrun", {47'h0, o_overrun}, 48'd0);
        check("rst_frame_err", {47'h0, o_frame_err}, 48'd0);
        @(posedge scki);
        #1 rst = 1'b1;

        // Lead-in right slot, then a basic pair
        send_slot(1'b1, 24'h0, 32);
        frame(24'h123456, 24'hABCDEF, 1'b1);
        drain("basic_drain");
        check("basic_ferr", 48'(ferr_cnt), 48'd0);

        // Generator-style loopback over 8 frames
        for (int i = 0; i < 8; i++) frame(lut[i], lut[(i + 2) % 8], 1'b1);
        drain("loop_drain");
        check("loop_ferr", 48'(ferr_cnt), 48'd0);
        check("loop_ovr", 48'(ovr_cnt), 48'd0);

        // Backpressure: the second pair overwrites the first
        sync_pt();
        i_ready = 1'b0;
        frame(24'h000001, 24'h000002, 1'b0);
        frame(24'h000003, 24'h000004, 1'b0);
        sync_pt();
        check("bp_ovr", 48'(ovr_cnt), 48'd1);
        check("bp_valid", {47'h0, o_valid}, 48'd1);
        check("bp_left", {24'h0, o_left}, 48'h000003);
        check("bp_right", {24'h0, o_right}, 48'h000004);
        exp_q.push_back({24'h000003, 24'h000004});
        i_ready = 1'b1;
        drain("bp_drain");
        repeat (3) sync_pt();
        check("bp_valid_low", {47'h0, o_valid}, 48'd0);

        // Short left slot, discarded right word, then a good pair
        send_slot(1'b0, 24'hFFFFFF, 10);
        send_slot(1'b1, 24'h555555, 32);
        check("short_ferr", 48'(ferr_cnt), 48'd1);
        check("short_no_pair", 48'(unexp_cnt), 48'd0);
        frame(24'hC0FFEE, 24'h0BADF0, 1'b1);
        drain("short_drain");

        // Reset in the middle of a left word
        send_slot(1'b0, 24'hC3C3C3, 13);
        @(posedge scki);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_left", {24'h0, o_left}, 48'd0);
        check("mid_rst_right", {24'h0, o_right}, 48'd0);
        check("mid_rst_valid", {47'h0, o_valid}, 48'd0);
        check("mid_rst_overrun", {47'h0, o_overrun}, 48'd0);
        check("mid_rst_ferr", {47'h0, o_frame_err}, 48'd0);
        repeat (3) @(posedge scki);
        #1 rst = 1'b1;
        send_slot(1'b0, 24'h0, 19);
        send_slot(1'b1, 24'h0F0F0F, 32);
        frame(24'h654321, 24'h13579B, 1'b1);
        drain("rst_drain");

        // Boundary data values
        frame(24'h800000, 24'h7FFFFF, 1'b1);
        frame(24'hFFFFFF, 24'hFFFFFF, 1'b1);
        drain("bound_drain");

        check("final_unexpected", 48'(unexp_cnt), 48'd0);
        check("final_ferr", 48'(ferr_cnt), 48'd1);
        check("final_ovr", 48'(ovr_cnt), 48'd1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Receiver counterpart to the team's PCM/I2S sine generator.
- Oversamples an external I2S stream (bck, lrck, adata) in the scki domain and deserialises MSB-first 24-bit stereo words.
- Presents each complete left/right pair on a valid/ready output port.
- Used for loopback verification of the generator and as the audio front end of the DSP chain.

Parameters:
- DATA_WIDTH, 24, audio word width in bits, MSB first.
- SYNC_STAGES, 2, synchroniser depth on bck/lrck/adata (minimum 2).
- LEFT_LRCK, 0, lrck level that marks the left channel slot.

Ports:
- scki  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- bck  input  1  I2S bit clock; asynchronous to scki; frequency <= scki/4.
- lrck  input  1  I2S word select.
- adata  input  1  I2S serial data; sampled on bck rising edge.
- i_ready  input  1  downstream accepts the current pair.
- o_left  output  DATA_WIDTH  left sample of the current pair.
- o_right  output  DATA_WIDTH  right sample of the current pair.
- o_valid  output  1  pair available; held until accepted.
- o_overrun  output  1  one-cycle pulse: unaccepted pair overwritten.
- o_frame_err  output  1  one-cycle pulse: slot ended before DATA_WIDTH bits.

Behaviour:
- Reset (async assert, sync release): o_left=0, o_right=0, o_valid=0, o_overrun=0, o_frame_err=0. Synchronisers=0, FSM=IDLE, bit counter=0, left-held flag=0.
- Input conditioning:
  - bck, lrck and adata each pass through SYNC_STAGES flops.
  - bck_rise = synced bck high AND previous synced bck low; one scki-cycle strobe.
  - All FSM activity occurs only on bck_rise cycles. lrck_s and adata_s are sampled on those cycles.
- Channel boundary: on a bck_rise where sampled lrck_s differs from lrck_s at the previous bck_rise.
- FSM states:
  - IDLE: ignore data until the first channel boundary, then go to DELAY. Partial frames after reset are discarded.
  - DELAY: consume the I2S one-bit delay (the bit sampled on the boundary bck_rise is discarded). Clear the bit counter. Next bck_rise goes to SHIFT.
  - SHIFT: shift adata_s into the shift register LSB-ward, MSB first, and increment the counter. On the DATA_WIDTH-th bit, latch the word into the channel selected by that slot's lrck, then go to PAD.
  - PAD: ignore bits until the next channel boundary, then go to DELAY.
- Short slot: a channel boundary while in SHIFT before DATA_WIDTH bits are received:
  - discard the word;
  - pulse o_frame_err;
  - clear the left-held flag;
  - go to DELAY.
- Pairing:
  - Left word completion: store in an internal left holding register and set the left-held flag.
  - Right word completion with the flag set: load o_left and o_right, assert o_valid, clear the flag.
  - Right word completion without the flag set: discard the word, leave outputs unchanged.
- Handshake:
  - Transfer occurs on a cycle with o_valid && i_ready.
  - o_valid drops the next cycle unless a new pair loads in that same cycle; the new pair takes priority and o_valid stays 1.
  - o_left and o_right are stable while o_valid=1 && !i_ready, except on overrun.
- Overrun: a new pair completes while o_valid=1 and i_ready=0:
  - overwrite o_left and o_right with the newest pair;
  - o_valid stays 1;
  - pulse o_overrun for one cycle.
- Latency: o_valid rises SYNC_STAGES+2 scki cycles after the first scki edge that samples raw bck high for the right word's last bit.
- Reset mid-frame: all state clears immediately and the FSM restarts in IDLE. A pending pair is lost.
- The bit counter saturates in PAD. Slots of any length >= DATA_WIDTH+1 bck periods are accepted.

Test Plan:
- Basic pair: scki/4 bck, 32-bit slots, left=24'h123456, right=24'hABCDEF after one lead-in frame, i_ready=1 → exactly one o_valid pulse with o_left=24'h123456, o_right=24'hABCDEF; o_frame_err=0.
- Generator loopback: drive from pcm_gen-style stimulus (lrck starting at 1, 32-bit slots) for 8 frames → o_valid once per frame, sample sequence matches the driven LUT values in order, no errors.
- Backpressure: i_ready=0 across two complete pairs (L1/R1=24'h000001/24'h000002, then 24'h000003/24'h000004) → o_valid held, single o_overrun pulse, outputs 24'h000003/24'h000004; raise i_ready → one transfer, then o_valid=0.
- Short slot: left slot of only 10 bits, then a normal right slot of 24'h555555 → o_frame_err pulse, no o_valid; the next full pair is delivered correctly.
- Reset mid-frame: assert rst after 12 bits of a left word → all outputs 0 immediately; after release, the first partial frame is ignored and the next complete pair is delivered.
- Boundary data: left=24'h800000, right=24'h7FFFFF, then both 24'hFFFFFF → MSB and LSB placement verified, values exact.
